// File: rtl/rv_decode_stage.sv
// RV32I/RV32IM decode stage: decodes one instruction per valid/ready transfer
// into a registered bundle with stall, flush and an accepted-bundle counter.
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ENABLE_M = 0,
    parameter int PASS_PC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [2:0]        out_func3,
    output logic [6:0]        out_func7,
    output logic [6:0]        out_opcode,
    output logic [XLEN-1:0]   out_imm,
    output logic [5:0]        out_fmt,
    output logic              out_rd_v,
    output logic              out_rs1_v,
    output logic              out_rs2_v,
    output logic              out_f3_v,
    output logic              out_f7_v,
    output logic              out_imm_v,
    output logic              out_illegal,
    output logic [31:0]       dec_count
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [2:0]        f3;
        logic [6:0]        f7, opc;
        logic [XLEN-1:0]   imm;
        logic [5:0]        fmt;   // {J,U,B,S,I,R}
        logic              rd_v, rs1_v, rs2_v, f3_v, f7_v, imm_v, ill;
    } bundle_t;

    bundle_t     bundle_d, bundle_q;
    logic        valid_q;
    logic [31:0] cnt_q;
    logic [5:0]  fmt;
    logic        ill;
    logic [31:0] imm32;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    logic        load, drain;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        fmt = 6'b0;
        ill = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opc)
                7'b0110011: begin
                    fmt = 6'b000001;
                    ill = !((f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                            (f7 == 7'b0000001 && ENABLE_M != 0));
                end
                7'b0010011, 7'b1110011: fmt = 6'b000010;
                7'b0000011: begin
                    fmt = 6'b000010;
                    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                end
                7'b1100111: begin
                    fmt = 6'b000010;
                    ill = (f3 != 3'b000);
                end
                7'b0100011: begin
                    fmt = 6'b000100;
                    ill = (f3 > 3'b010);
                end
                7'b1100011: begin
                    fmt = 6'b001000;
                    ill = (f3 == 3'b010) || (f3 == 3'b011);
                end
                7'b0110111, 7'b0010111: fmt = 6'b010000;
                7'b1101111: fmt = 6'b100000;
                default: ill = 1'b1;
            endcase
        end
        // Illegal encodings carry no format, so every flag and the immediate clear too
        if (ill) fmt = 6'b0;

        imm32 = 32'b0;
        if (fmt[1]) imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        if (fmt[2]) imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        if (fmt[3]) imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
        if (fmt[4]) imm32 = {in_instr[31:12], 12'b0};
        if (fmt[5]) imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};

        bundle_d       = '0;
        bundle_d.pc    = (PASS_PC != 0) ? in_pc : '0;
        bundle_d.rs1   = REG_AW'(in_instr[19:15]);
        bundle_d.rs2   = REG_AW'(in_instr[24:20]);
        bundle_d.rd    = REG_AW'(in_instr[11:7]);
        bundle_d.f3    = f3;
        bundle_d.f7    = f7;
        bundle_d.opc   = opc;
        bundle_d.imm   = XLEN'($signed(imm32));
        bundle_d.fmt   = fmt;
        bundle_d.rd_v  = fmt[0] | fmt[1] | fmt[4] | fmt[5];
        bundle_d.rs1_v = |fmt[3:0];
        bundle_d.rs2_v = fmt[0] | fmt[2] | fmt[3];
        bundle_d.f3_v  = |fmt[3:0];
        bundle_d.f7_v  = fmt[0];
        bundle_d.imm_v = |fmt[5:1];
        bundle_d.ill   = ill;
    end

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign drain    = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            // A transfer completing alongside flush still counts
            if (drain) cnt_q <= cnt_q + 32'd1;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (load) begin
                bundle_q <= bundle_d;
                valid_q  <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = bundle_q.pc;
    assign out_rs1     = bundle_q.rs1;
    assign out_rs2     = bundle_q.rs2;
    assign out_rd      = bundle_q.rd;
    assign out_func3   = bundle_q.f3;
    assign out_func7   = bundle_q.f7;
    assign out_opcode  = bundle_q.opc;
    assign out_imm     = bundle_q.imm;
    assign out_fmt     = bundle_q.fmt;
    assign out_rd_v    = bundle_q.rd_v;
    assign out_rs1_v   = bundle_q.rs1_v;
    assign out_rs2_v   = bundle_q.rs2_v;
    assign out_f3_v    = bundle_q.f3_v;
    assign out_f7_v    = bundle_q.f7_v;
    assign out_imm_v   = bundle_q.imm_v;
    assign out_illegal = bundle_q.ill;
    assign dec_count   = cnt_q;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: two instances (base ISA with PC, M-enabled
// without PC) share one stimulus stream; expectations are hand-decoded.
module tb_rv_decode_stage;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_instr = 32'h0, in_pc = 32'h0;

    logic        a_in_ready, a_valid, a_rd_v, a_rs1_v, a_rs2_v, a_f3_v, a_f7_v, a_imm_v, a_ill;
    logic [31:0] a_pc, a_imm, a_cnt;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7, a_opc;
    logic [5:0]  a_fmt;

    logic        m_in_ready, m_valid, m_rd_v, m_rs1_v, m_rs2_v, m_f3_v, m_f7_v, m_imm_v, m_ill;
    logic [31:0] m_pc, m_imm, m_cnt;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7, m_opc;
    logic [5:0]  m_fmt;

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .REG_AW(5), .ENABLE_M(0), .PASS_PC(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_func3(a_f3),
        .out_func7(a_f7), .out_opcode(a_opc), .out_imm(a_imm), .out_fmt(a_fmt),
        .out_rd_v(a_rd_v), .out_rs1_v(a_rs1_v), .out_rs2_v(a_rs2_v), .out_f3_v(a_f3_v),
        .out_f7_v(a_f7_v), .out_imm_v(a_imm_v), .out_illegal(a_ill), .dec_count(a_cnt));

    rv_decode_stage #(.XLEN(32), .REG_AW(5), .ENABLE_M(1), .PASS_PC(0)) u_m (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_valid), .out_ready(out_ready),
        .out_pc(m_pc), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_rd(m_rd), .out_func3(m_f3),
        .out_func7(m_f7), .out_opcode(m_opc), .out_imm(m_imm), .out_fmt(m_fmt),
        .out_rd_v(m_rd_v), .out_rs1_v(m_rs1_v), .out_rs2_v(m_rs2_v), .out_f3_v(m_f3_v),
        .out_f7_v(m_f7_v), .out_imm_v(m_imm_v), .out_illegal(m_ill), .dec_count(m_cnt));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags order {rd,rs1,rs2,f3,f7,imm}; fmt order {J,U,B,S,I,R}
    task automatic chk_dec(input string tag, input logic [5:0] fmt, input logic [5:0] flags,
                           input logic ill, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] cnt);
        chk({tag, ".valid"}, a_valid, 1'b1);
        chk({tag, ".fmt"}, a_fmt, fmt);
        chk({tag, ".flags"}, {a_rd_v, a_rs1_v, a_rs2_v, a_f3_v, a_f7_v, a_imm_v}, flags);
        chk({tag, ".ill"}, a_ill, ill);
        chk({tag, ".regs"}, {a_rd, a_rs1, a_rs2}, {rd, rs1, rs2});
        chk({tag, ".imm"}, a_imm, imm);
        chk({tag, ".cnt"}, a_cnt, cnt);
    endtask

    task automatic feed(input logic [31:0] instr, input logic [31:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        step();
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("rst.valid", a_valid, 1'b0);
        chk("rst.cnt", a_cnt, 32'd0);
        chk("rst.fields", {a_pc, a_imm, a_fmt, a_ill}, '0);
        chk("rst.in_ready", a_in_ready, 1'b1);

        feed(32'h00500093, 32'h100);
        chk_dec("addi", 6'b000010, 6'b110101, 1'b0, 5'd1, 5'd0, 5'd5, 32'd5, 32'd0);
        chk("addi.pc", a_pc, 32'h100);
        chk("addi.pc_off", m_pc, 32'h0);
        feed(32'hFE20AE23, 32'h104);
        chk_dec("sw", 6'b000100, 6'b011101, 1'b0, 5'd28, 5'd1, 5'd2, 32'hFFFFFFFC, 32'd1);
        chk("sw.f3", a_f3, 3'b010);
        feed(32'h008000EF, 32'h108);
        chk_dec("jal", 6'b100000, 6'b100001, 1'b0, 5'd1, 5'd0, 5'd8, 32'd8, 32'd2);
        feed(32'h123452B7, 32'h10C);
        chk_dec("lui", 6'b010000, 6'b100001, 1'b0, 5'd5, 5'd8, 5'd3, 32'h12345000, 32'd3);
        feed(32'h00000000, 32'h110);
        chk_dec("zero", 6'b000000, 6'b000000, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd4);
        feed(32'h022081B3, 32'h114);
        chk_dec("mul.noM", 6'b000000, 6'b000000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'd5);
        chk("mul.noM.f7", a_f7, 7'b0000001);
        chk("mul.M.fmt", m_fmt, 6'b000001);
        chk("mul.M.ill", m_ill, 1'b0);
        chk("mul.M.rd", m_rd, 5'd3);
        chk("mul.M.f7", m_f7, 7'b0000001);
        feed(32'h00208463, 32'h118);
        chk_dec("beq", 6'b001000, 6'b011101, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 32'd6);
        feed(32'h40000033, 32'h11C);
        chk_dec("sub", 6'b000001, 6'b111110, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd7);
        feed(32'h40001033, 32'h120);
        chk_dec("sub.f3bad", 6'b000000, 6'b000000, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd8);
        feed(32'h00003003, 32'h124);
        chk_dec("load.f3bad", 6'b000000, 6'b000000, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd9);
        feed(32'h00500091, 32'h128);
        chk_dec("low2bad", 6'b000000, 6'b000000, 1'b1, 5'd1, 5'd0, 5'd5, 32'd0, 32'd10);
        chk("low2bad.opc", a_opc, 7'h11);

        // stall three cycles with a new instruction waiting
        out_ready = 1'b0;
        in_instr  = 32'h00500093;
        #1;
        chk("stall.in_ready0", a_in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.in_ready", a_in_ready, 1'b0);
            chk("stall.valid", a_valid, 1'b1);
            chk("stall.opc", a_opc, 7'h11);
            chk("stall.pc", a_pc, 32'h128);
            chk("stall.cnt", a_cnt, 32'd10);
        end
        out_ready = 1'b1;
        step();
        chk_dec("release", 6'b000010, 6'b110101, 1'b0, 5'd1, 5'd0, 5'd5, 32'd5, 32'd11);
        feed(32'h008000EF, 32'h12C);
        chk_dec("b2b", 6'b100000, 6'b100001, 1'b0, 5'd1, 5'd0, 5'd8, 32'd8, 32'd12);

        // flush while stalled: no count, no load
        out_ready = 1'b0;
        flush     = 1'b1;
        feed(32'hFE20AE23, 32'h130);
        chk("flush.valid", a_valid, 1'b0);
        chk("flush.cnt", a_cnt, 32'd12);
        chk("flush.noload", a_opc, 7'h6F);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush.idle", a_valid, 1'b0);

        // flush coinciding with a completing transfer still counts it
        out_ready = 1'b1;
        feed(32'h123452B7, 32'h134);
        chk("pre.flush2.valid", a_valid, 1'b1);
        flush = 1'b1;
        feed(32'hFE20AE23, 32'h138);
        chk("flush2.valid", a_valid, 1'b0);
        chk("flush2.cnt", a_cnt, 32'd13);
        chk("flush2.noload", a_opc, 7'h37);
        flush = 1'b0;

        // reset mid-stream
        feed(32'h00500093, 32'h13C);
        chk("mid.valid", a_valid, 1'b1);
        rst = 1'b1;
        feed(32'h008000EF, 32'h140);
        chk("rst2.valid", a_valid, 1'b0);
        chk("rst2.cnt", a_cnt, 32'd0);
        chk("rst2.fields", {a_pc, a_imm, a_rd, a_fmt, a_opc, a_rd_v, a_imm_v}, '0);
        chk("rst2.m.cnt", m_cnt, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, parametrised RV32I/RV32IM instruction decode stage between fetch and register-read/execute.
- Accepts one instruction word plus PC per transfer over a valid/ready handshake.
- Decodes fields, format and sign-extended immediate, plus per-field valid flags and an illegal-instruction flag.
- Holds the result in an output pipeline register with stall and flush support.

Parameters:
- XLEN, 32, data/PC width; immediate is sign-extended to XLEN.
- REG_AW, 5, register index width; upper bits of a field are zero when REG_AW > 5.
- ENABLE_M, 0, 1 = funct7 0000001 on opcode 0110011 is legal (M extension); 0 = illegal.
- PASS_PC, 1, 1 = out_pc carries in_pc; 0 = out_pc tied to zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discards held and incoming instruction this cycle.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  REG_AW  register indices.
- out_func3  out  3  instr[14:12].
- out_func7  out  7  instr[31:25].
- out_opcode  out  7  instr[6:0].
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  6  one-hot {J,U,B,S,I,R}; all zero if illegal.
- out_rd_v, out_rs1_v, out_rs2_v, out_f3_v, out_f7_v, out_imm_v  out  1 each  field-used flags.
- out_illegal  out  1  unrecognised opcode/encoding.
- dec_count  out  32  count of bundles accepted downstream.

Behaviour:
- Reset: all out_* registers 0, out_valid 0, dec_count 0; in_ready reads 1 the cycle after reset deasserts.
- in_ready = !out_valid || out_ready (combinational); it is the only combinational path from out_ready.
- Load: on clk when in_valid && in_ready && !flush, all out_* fields register from decode of in_instr; out_valid <= 1. Latency is 1 cycle.
- Drain: when out_valid && out_ready and no load, out_valid <= 0. Simultaneous drain and load gives back-to-back throughput of 1/cycle.
- Stall: out_valid && !out_ready holds every output stable; in_ready = 0.
- flush: out_valid <= 0 next cycle regardless of other inputs; no load occurs. dec_count does not increment for a bundle flushed while out_ready = 0.
- dec_count increments on every out_valid && out_ready edge, including a cycle with flush high (that transfer completes), and wraps at 2^32.
- rst overrides flush and any handshake.
- Format by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode, or instr[1:0] != 11, sets out_illegal.
- Immediates (sign bit instr[31]):
  - I = [31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],0}.
  - R and illegal: imm = 0.
- Valid flags:
  - rd_v: R, I, U, J.
  - rs1_v: R, I, S, B.
  - rs2_v: R, S, B.
  - f3_v: R, I, S, B.
  - f7_v: R only.
  - imm_v: everything except R.
  - All flags are 0 when illegal.
- Extra illegal cases:
  - R with func7 not in {0000000, 0100000}, plus 0000001 when ENABLE_M=1.
  - R with func7 0100000 and func3 not in {000, 101}.
  - Loads with func3 in {011, 110, 111}.
  - Stores with func3 > 010.
  - Branches with func3 in {010, 011}.
  - JALR with func3 != 000.
- Illegal instructions still transfer as normal bundles, with out_illegal = 1 and raw fields populated.

Test Plan:
- Reset, then in 0x00500093 -> next cycle out_valid = 1, fmt I, rd 1, rs1 0, imm 5, rs2_v 0, illegal 0.
- 0xFE20AE23 -> fmt S, rs1 1, rs2 2, imm 0xFFFFFFFC, rd_v 0. Then 0x008000EF -> fmt J, rd 1, imm 8.
- 0x123452B7 then 0x00000000 -> imm 0x12345000 fmt U; then out_illegal 1, fmt 0, all flags 0.
- 0x022081B3 with ENABLE_M=0 -> illegal 1; with ENABLE_M=1 -> fmt R, rd 3, f7 0000001, illegal 0.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready 0, outputs stable, dec_count unchanged. Release -> 1 transfer/cycle, dec_count +1 per transfer.
- flush while stalled with a bundle held -> out_valid 0 next cycle, no load that cycle. rst asserted mid-stream -> all outputs 0 next cycle.
